// File: rtl/tc0260dar.sv
// TC0260DAR palette RAM / colour DAC.
// One single-port palette RAM shared between the pixel path (priority on ce_pixel
// clocks) and a CPU port that is served in the next free clk.
module tc0260dar #(
    parameter int ADDR_W = 13
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ce_pixel,
    input  logic [ADDR_W-1:0] color_in,
    input  logic              blank,
    input  logic              rgb_mode,
    input  logic              cs,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_rw,
    input  logic [1:0]        cpu_ds_n,
    input  logic [15:0]       cpu_din,
    output logic [15:0]       cpu_dout,
    output logic              cpu_dtack_n,
    output logic [7:0]        red,
    output logic [7:0]        green,
    output logic [7:0]        blue
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {IDLE, PEND, DONE} state_t;

    state_t      state;
    logic [15:0] ram [DEPTH];
    logic [15:0] pix_word;
    logic        pix_valid;
    logic        pix_blank;
    logic        cs_block;   // set by reset: a cs held across reset must drop before it counts
    logic        cpu_acc;
    logic        unused_bit;

    // The CPU owns the RAM only in clks where the pixel path does not need it.
    assign cpu_acc = !reset && cs && !ce_pixel &&
                     ((state == IDLE && !cs_block) || state == PEND);

    // Bit 15 carries no colour in either format.
    assign unused_bit = pix_word[15];

    // Palette RAM: pixel read on ce_pixel, CPU byte-masked write otherwise; never reset.
    always_ff @(posedge clk) begin
        if (ce_pixel) begin
            pix_word <= ram[color_in];
        end
        if (cpu_acc && !cpu_rw) begin
            if (!cpu_ds_n[1]) ram[cpu_addr][15:8] <= cpu_din[15:8];
            if (!cpu_ds_n[0]) ram[cpu_addr][7:0]  <= cpu_din[7:0];
        end
    end

    // Conversion stage: blank and rgb_mode applied when the fetched word is converted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pix_valid <= 1'b0;
            pix_blank <= 1'b1;
            red       <= 8'h00;
            green     <= 8'h00;
            blue      <= 8'h00;
        end else begin
            pix_valid <= ce_pixel;
            if (ce_pixel) begin
                pix_blank <= blank;
            end
            if (pix_valid) begin
                if (pix_blank) begin
                    red   <= 8'h00;
                    green <= 8'h00;
                    blue  <= 8'h00;
                end else if (rgb_mode) begin
                    red   <= {pix_word[14:10], pix_word[14:12]};
                    green <= {pix_word[9:5],   pix_word[9:7]};
                    blue  <= {pix_word[4:0],   pix_word[4:2]};
                end else begin
                    red   <= {pix_word[11:8], pix_word[11:8]};
                    green <= {pix_word[7:4],  pix_word[7:4]};
                    blue  <= {pix_word[3:0],  pix_word[3:0]};
                end
            end
        end
    end

    // CPU handshake FSM: one access per cs assertion, acknowledged until cs drops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cpu_dtack_n <= 1'b1;
            cpu_dout    <= 16'h0000;
            cs_block    <= 1'b1;
        end else begin
            if (!cs) begin
                cs_block <= 1'b0;
            end
            if (cpu_acc && cpu_rw) begin
                cpu_dout <= ram[cpu_addr];
            end
            case (state)
                IDLE: begin
                    if (cs && !cs_block) begin
                        if (ce_pixel) begin
                            state <= PEND;
                        end else begin
                            state       <= DONE;
                            cpu_dtack_n <= 1'b0;
                        end
                    end
                end
                PEND: begin
                    if (!cs) begin
                        state <= IDLE;
                    end else if (!ce_pixel) begin
                        state       <= DONE;
                        cpu_dtack_n <= 1'b0;
                    end
                end
                DONE: begin
                    if (!cs) begin
                        state       <= IDLE;
                        cpu_dtack_n <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    cpu_dtack_n <= 1'b1;
                end
            endcase
        end
    end

endmodule
